// File: rtl/bcd_digits_to_binary.sv
// bcd_digits_to_binary
// Sequential BCD-to-binary converter. A start pulse captures NUM_DIGITS packed
// BCD digits. They are folded most-significant-first as value = value*10 + digit,
// one digit per clock. The result and the done/error flags are held in registers
// so that they can be read directly as a readdata word.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   start     in   single-cycle request; digits_in sampled on the same edge
//   digits_in in   packed BCD, digit k = [4k+3:4k], digit0 least significant
//   busy      out  high while a conversion is in progress
//   done      out  sticky result-valid flag, cleared by the next accepted start
//   error     out  a sampled digit was greater than 9 (valid when done=1)
//   value     out  binary result (valid when done=1)
module bcd_digits_to_binary #(
  parameter int NUM_DIGITS = 6,
  parameter int OUT_WIDTH  = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [OUT_WIDTH-1:0]    value
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  // Returns 1 when any nibble of the packed word is not a decimal digit.
  function automatic logic has_bad_digit(input logic [4*NUM_DIGITS-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (d[4*k +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // acc*10 + digit, built as (acc<<3) + (acc<<1) + digit. No multiplier is
  // used, and the result wraps at OUT_WIDTH bits.
  function automatic logic [OUT_WIDTH-1:0] times10_add(
    input logic [OUT_WIDTH-1:0] acc,
    input logic [3:0]           digit
  );
    return {acc[OUT_WIDTH-4:0], 3'b000} + {acc[OUT_WIDTH-2:0], 1'b0} +
           {{(OUT_WIDTH-4){1'b0}}, digit};
  endfunction

  state_e                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [OUT_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]    value_q, value_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    busy_q, busy_d;

  logic [3:0]              digit_s;
  logic [OUT_WIDTH-1:0]    acc_next_s;

  assign digit_s    = digits_q[4*cnt_q +: 4];
  assign acc_next_s = times10_add(acc_q, digit_s);

  // Next-state and output logic. value only moves at completion or on an
  // invalid request, so a reader never sees a partial sum.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    done_d   = done_q;
    error_d  = error_q;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          digits_d = digits_in;
          acc_d    = {OUT_WIDTH{1'b0}};
          cnt_d    = CNT_LAST;
          if (has_bad_digit(digits_in)) begin
            // Invalid input completes immediately with an error result.
            state_d = S_DONE;
            value_d = {OUT_WIDTH{1'b0}};
            done_d  = 1'b1;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_CONVERT;
            done_d  = 1'b0;
            error_d = 1'b0;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_CONVERT: begin
        // A start pulse in this state is ignored.
        acc_d = acc_next_s;
        if (cnt_q == CNT_ZERO) begin
          state_d = S_DONE;
          value_d = acc_next_s;
          done_d  = 1'b1;
          error_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        // An unreachable encoding falls back to a clean idle state.
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything, including a
  // conversion that is in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      digits_q <= {(4*NUM_DIGITS){1'b0}};
      acc_q    <= {OUT_WIDTH{1'b0}};
      cnt_q    <= CNT_ZERO;
      value_q  <= {OUT_WIDTH{1'b0}};
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      done_q   <= done_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;
  assign value = value_q;

endmodule

// File: tb/tb_bcd_digits_to_binary.sv
// Directed and random stimulus for bcd_digits_to_binary. A scoreboard queue
// holds the expected {error, value} for each accepted start.
module tb_bcd_digits_to_binary;

  localparam int ND = 6;
  localparam int OW = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [4*ND-1:0] digits_in;
  logic          busy;
  logic          done;
  logic          error;
  logic [OW-1:0] value;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [OW:0]   exp_q[$];
  logic [OW-1:0] last_value;

  bcd_digits_to_binary #(.NUM_DIGITS(ND), .OUT_WIDTH(OW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .digits_in(digits_in),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .value    (value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic is_bad(input logic [4*ND-1:0] d);
    logic b;
    b = 1'b0;
    for (int k = 0; k < ND; k++) if (d[4*k +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [OW-1:0] ref_bcd(input logic [4*ND-1:0] d);
    logic [31:0] v;
    v = 32'd0;
    for (int k = ND - 1; k >= 0; k--) v = v * 32'd10 + {28'd0, d[4*k +: 4]};
    return v[OW-1:0];
  endfunction

  // Called at a negedge. Drives start for one edge, pushes the expectation
  // and returns at the negedge after the sampling edge (edge 0).
  task automatic issue_start(input logic [4*ND-1:0] d);
    start     = 1'b1;
    digits_in = d;
    if (is_bad(d)) exp_q.push_back({1'b1, {OW{1'b0}}});
    else           exp_q.push_back({1'b0, ref_bcd(d)});
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    digits_in = 24'($urandom);
  endtask

  task automatic pop_compare(input string tag);
    logic [OW:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = {(OW+1){1'b1}};
    check({tag, "_value"}, 32'(value), 32'(e[OW-1:0]));
    check({tag, "_error"}, 32'(error), 32'(e[OW]));
    last_value = e[OW-1:0];
  endtask

  // Follows a valid conversion from the negedge after edge 0 through edge ND.
  // If inject is between 1 and ND, a stray start with 0x777777 is driven
  // during that cycle.
  task automatic finish_conv(input string tag, input int inject);
    for (int i = 1; i <= ND; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done_low"}, 32'(done), 32'd0);
      check({tag, "_value_hold"}, 32'(value), 32'(last_value));
      if (i == inject) begin
        start     = 1'b1;
        digits_in = 24'h777777;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    pop_compare(tag);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    digits_in  = 24'h000000;
    last_value = 20'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Basic conversion.
    issue_start(24'h123456);
    finish_conv("c123456", 0);
    check("c123456_const", 32'(value), 32'h1E240);

    // Back-to-back conversions, each started from DONE.
    issue_start(24'h999999);
    finish_conv("c999999", 0);
    check("c999999_const", 32'(value), 32'hF423F);
    issue_start(24'h000000);
    finish_conv("c000000", 0);

    // An invalid digit completes immediately with an error.
    issue_start(24'h12A456);
    check("bad_done", 32'(done), 32'd1);
    check("bad_busy", 32'(busy), 32'd0);
    pop_compare("bad");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bad_busy_stays_low", 32'(busy), 32'd0);
      check("bad_done_sticky", 32'(done), 32'd1);
      check("bad_error_sticky", 32'(error), 32'd1);
    end

    // A start pulse during the conversion is ignored.
    issue_start(24'h000042);
    finish_conv("c42_ignore", 3);
    check("c42_const", 32'(value), 32'd42);
    repeat (ND + 1) begin
      @(negedge clk);
      check("c42_after_busy", 32'(busy), 32'd0);
      check("c42_after_value", 32'(value), 32'd42);
    end

    // Reset in the middle of a conversion.
    issue_start(24'h654321);
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_value", 32'(value), 32'd0);
    exp_q.delete();
    last_value = 20'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_done", 32'(done), 32'd0);
    issue_start(24'h000010);
    finish_conv("c10", 0);
    check("c10_const", 32'(value), 32'd10);

    // Random valid conversions against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [4*ND-1:0] d;
      for (int k = 0; k < ND; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
      issue_start(d);
      finish_conv("rand", 0);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
